// File: rtl/button_conditioner.sv
// button_conditioner
// Turns a raw, bouncing board push-button into clean single-cycle enable
// pulses: polarity adjustment, two-flop synchroniser, press/release debounce
// and optional auto-repeat while the button is held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int REPEAT_DELAY       = 64,
    parameter int REPEAT_PERIOD      = 16,
    parameter bit BUTTON_ACTIVE_HIGH = 1'b1
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic button_i,
    output logic enable_o,
    output logic button_level_o,
    output logic release_o
);

    // Counter widths: the debounce counter only has to reach DEBOUNCE_CYCLES-1,
    // the repeat counter the larger of the two repeat intervals minus one.
    localparam int DCNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX_RAW   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RMAX       = (RMAX_RAW > 2) ? RMAX_RAW : 2;
    localparam int RCNT_W     = $clog2(RMAX);
    localparam bit REPEAT_EN  = (REPEAT_DELAY != 0);

    localparam logic [DCNT_W-1:0] DCNT_ONE     = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_LAST    = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE     = RCNT_W'(1);
    localparam logic [RCNT_W-1:0] RDELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RPERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_RELEASED      = 2'd0,
        ST_PRESS_CHECK   = 2'd1,
        ST_PRESSED       = 2'd2,
        ST_RELEASE_CHECK = 2'd3
    } state_t;

    logic              pin_s;
    logic              sync_meta_r;
    logic              btn_sync_r;
    state_t            state_r;
    logic [DCNT_W-1:0] dcnt_r;
    logic [RCNT_W-1:0] rcnt_r;
    logic              first_done_r;
    logic              enable_r;
    logic              level_r;
    logic              release_r;

    // Map the pin so that 1 always means "pressed" before synchronising.
    always_comb begin
        if (BUTTON_ACTIVE_HIGH) begin
            pin_s = button_i;
        end else begin
            pin_s = ~button_i;
        end
    end

    // Two-flop synchroniser; resets to the not-pressed level.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_meta_r <= 1'b0;
            btn_sync_r  <= 1'b0;
        end else begin
            sync_meta_r <= pin_s;
            btn_sync_r  <= sync_meta_r;
        end
    end

    // Debounce / auto-repeat state machine with registered pulse and level outputs.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= ST_RELEASED;
            dcnt_r       <= {DCNT_W{1'b0}};
            rcnt_r       <= {RCNT_W{1'b0}};
            first_done_r <= 1'b0;
            enable_r     <= 1'b0;
            level_r      <= 1'b0;
            release_r    <= 1'b0;
        end else begin
            enable_r  <= 1'b0;
            release_r <= 1'b0;
            case (state_r)
                ST_RELEASED: begin
                    level_r <= 1'b0;
                    if (btn_sync_r) begin
                        state_r <= ST_PRESS_CHECK;
                        dcnt_r  <= DCNT_ONE;
                    end else begin
                        state_r <= ST_RELEASED;
                    end
                end
                ST_PRESS_CHECK: begin
                    if (!btn_sync_r) begin
                        // Bounce: drop back without a pulse.
                        state_r <= ST_RELEASED;
                        level_r <= 1'b0;
                    end else if (dcnt_r == DCNT_LAST) begin
                        state_r      <= ST_PRESSED;
                        enable_r     <= 1'b1;
                        level_r      <= 1'b1;
                        rcnt_r       <= {RCNT_W{1'b0}};
                        first_done_r <= 1'b0;
                    end else begin
                        dcnt_r  <= dcnt_r + DCNT_ONE;
                        level_r <= 1'b0;
                    end
                end
                ST_PRESSED: begin
                    level_r <= 1'b1;
                    if (!btn_sync_r) begin
                        state_r <= ST_RELEASE_CHECK;
                        dcnt_r  <= DCNT_ONE;
                    end else if (REPEAT_EN) begin
                        if (!first_done_r && (rcnt_r == RDELAY_LAST)) begin
                            enable_r     <= 1'b1;
                            rcnt_r       <= {RCNT_W{1'b0}};
                            first_done_r <= 1'b1;
                        end else if (first_done_r && (rcnt_r == RPERIOD_LAST)) begin
                            enable_r <= 1'b1;
                            rcnt_r   <= {RCNT_W{1'b0}};
                        end else begin
                            rcnt_r <= rcnt_r + RCNT_ONE;
                        end
                    end else begin
                        rcnt_r <= rcnt_r;
                    end
                end
                ST_RELEASE_CHECK: begin
                    // rcnt_r and first_done_r are frozen here so a release
                    // bounce neither restarts nor adds repeats.
                    if (btn_sync_r) begin
                        state_r <= ST_PRESSED;
                        level_r <= 1'b1;
                    end else if (dcnt_r == DCNT_LAST) begin
                        state_r   <= ST_RELEASED;
                        release_r <= 1'b1;
                        level_r   <= 1'b0;
                    end else begin
                        dcnt_r  <= dcnt_r + DCNT_ONE;
                        level_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_RELEASED;
                    dcnt_r       <= {DCNT_W{1'b0}};
                    rcnt_r       <= {RCNT_W{1'b0}};
                    first_done_r <= 1'b0;
                    level_r      <= 1'b0;
                end
            endcase
        end
    end

    assign enable_o       = enable_r;
    assign button_level_o = level_r;
    assign release_o      = release_r;

endmodule
